led_blink_ctrl: RTL and testbench

Downstream consumer of the 1 ms tick generator: turns the single-cycle `iTick1ms` strobe into a programmable LED blink pattern. Each burst is N ON/OFF pulses with millisecond-resolution phase lengths, optionally followed by a gap and an automatic repeat. It drives the board LED pin directly and reports `oBusy` and `oDone` to the controlling logic.

---
 rtl/led_blink_pkg.sv | 7 +
 rtl/led_blink_ctrl_if.sv | 34 +++
 rtl/ms_phase_timer.sv | 23 ++
 rtl/led_blink_ctrl.sv | 116 +++++++++++
 tb/tb_led_blink_ctrl.sv | 134 +++++++++++++
 5 files changed

// File: rtl/led_blink_pkg.sv
// led_blink_pkg: shared state encoding and default widths for the LED blink controller
package led_blink_pkg;
  localparam int MS_W_DEF = 16;
  localparam int BLINK_W_DEF = 4;
  localparam int PWM_W = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_GAP} state_e;
endpackage

// File: rtl/led_blink_ctrl_if.sv
// led_blink_ctrl_if: control/config/status bundle of the LED blink controller (iDuty only with LED_BLINK_DIM_EN)
interface led_blink_ctrl_if #(
  parameter int MS_W = 16,
  parameter int BLINK_W = 4
);
  logic iTick1ms;
  logic iStart;
  logic iStop;
  logic [BLINK_W-1:0] iBlinkCnt;
  logic [MS_W-1:0] iOnMs;
  logic [MS_W-1:0] iOffMs;
  logic [MS_W-1:0] iGapMs;
  logic iRepeat;
`ifdef LED_BLINK_DIM_EN
  logic [3:0] iDuty;
`endif
  logic oLed;
  logic oBusy;
  logic oDone;
  modport master (
    output iTick1ms, iStart, iStop, iBlinkCnt, iOnMs, iOffMs, iGapMs, iRepeat,
`ifdef LED_BLINK_DIM_EN
    output iDuty,
`endif
    input oLed, oBusy, oDone
  );
  modport slave (
    input iTick1ms, iStart, iStop, iBlinkCnt, iOnMs, iOffMs, iGapMs, iRepeat,
`ifdef LED_BLINK_DIM_EN
    input iDuty,
`endif
    output oLed, oBusy, oDone
  );
endinterface

// File: rtl/ms_phase_timer.sv
// ms_phase_timer: counts 1 ms ticks within a phase and flags the tick that ends it (length 0 acts as 1)
module ms_phase_timer #(
  parameter int MS_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iClr,
  input  logic            iTick1ms,
  input  logic [MS_W-1:0] iLen,
  output logic            oEnd
);
  logic [MS_W-1:0] cnt_q, cnt_d, last;
  // end on the tick where the count reaches max(len,1)-1; clear wins over counting
  always_comb begin
    last = (iLen == '0) ? '0 : iLen - 1'b1;
    oEnd = iTick1ms && (cnt_q == last);
    cnt_d = iClr ? '0 : iTick1ms ? cnt_q + 1'b1 : cnt_q;
  end
  // phase counter register
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
  end
endmodule

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: tick-driven LED burst/repeat blinker; LED_BLINK_DIM_EN adds a 4-bit PWM duty on the ON phase
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter int MS_W = MS_W_DEF,
  parameter int BLINK_W = BLINK_W_DEF
) (
  input logic clk,
  input logic rst,
  led_blink_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [BLINK_W-1:0] cnt_cfg_q, cnt_cfg_d, pulse_q, pulse_d, pulse_nx;
  logic [MS_W-1:0] on_q, on_d, off_q, off_d, gap_q, gap_d, len;
  logic rep_q, rep_d, done_q, done_d, ph_end, clr, accept;
`ifdef LED_BLINK_DIM_EN
  logic [PWM_W-1:0] duty_q, duty_d, pwm_q, pwm_d;
`endif

  ms_phase_timer #(.MS_W(MS_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .iClr     (clr),
    .iTick1ms (bus.iTick1ms),
    .iLen     (len),
    .oEnd     (ph_end)
  );

  // burst sequencing, config capture on accepted start, stop overriding everything
  always_comb begin
    accept = bus.iStart && (bus.iBlinkCnt != '0);
    pulse_nx = pulse_q + 1'b1;
    state_d = state_q;
    pulse_d = pulse_q;
    done_d = 1'b0;
    cnt_cfg_d = cnt_cfg_q;
    on_d = on_q;
    off_d = off_q;
    gap_d = gap_q;
    rep_d = rep_q;
`ifdef LED_BLINK_DIM_EN
    duty_d = duty_q;
    pwm_d = pwm_q + 1'b1;
`endif
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_ON;
        cnt_cfg_d = bus.iBlinkCnt;
        on_d = bus.iOnMs;
        off_d = bus.iOffMs;
        gap_d = bus.iGapMs;
        rep_d = bus.iRepeat;
`ifdef LED_BLINK_DIM_EN
        duty_d = bus.iDuty;
`endif
      end
      ST_ON: state_d = ph_end ? ST_OFF : ST_ON;
      ST_OFF: if (ph_end) begin
        pulse_d = pulse_nx;
        state_d = (pulse_nx < cnt_cfg_q) ? ST_ON : rep_q ? ST_GAP : ST_IDLE;
        done_d = (pulse_nx >= cnt_cfg_q) && !rep_q;
      end
      ST_GAP: if (ph_end) begin
        state_d = ST_ON;
        pulse_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.iStop) begin
      state_d = ST_IDLE;
      done_d = 1'b0;
    end
    if (state_d == ST_IDLE) pulse_d = '0;
    clr = (state_d != state_q) || (state_q == ST_IDLE);
    len = (state_q == ST_ON) ? on_q : (state_q == ST_OFF) ? off_q : gap_q;
  end

  // state, counters and captured configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pulse_q <= '0;
      done_q <= 1'b0;
      cnt_cfg_q <= '0;
      on_q <= '0;
      off_q <= '0;
      gap_q <= '0;
      rep_q <= 1'b0;
`ifdef LED_BLINK_DIM_EN
      duty_q <= '0;
      pwm_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      done_q <= done_d;
      cnt_cfg_q <= cnt_cfg_d;
      on_q <= on_d;
      off_q <= off_d;
      gap_q <= gap_d;
      rep_q <= rep_d;
`ifdef LED_BLINK_DIM_EN
      duty_q <= duty_d;
      pwm_q <= pwm_d;
`endif
    end
  end

  assign bus.oBusy = (state_q != ST_IDLE);
  assign bus.oDone = done_q;
`ifdef LED_BLINK_DIM_EN
  assign bus.oLed = (state_q == ST_ON) && (pwm_q < duty_q);
`else
  assign bus.oLed = (state_q == ST_ON);
`endif
endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb_led_blink_ctrl: directed and random stimulus checked against a tick-position model of the blink pattern
module tb_led_blink_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_blink_ctrl_if #(.MS_W(16), .BLINK_W(4)) bus ();
  led_blink_ctrl #(.MS_W(16), .BLINK_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0, n_fail = 0;
  bit m_act = 0, m_rep = 0;
  int m_k = 0, m_cnt = 0, m_on = 0, m_off = 0, m_gap = 0, m_pwm = 0, m_duty = 0;

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic cfg(input int cnt, input int on, input int off, input int gap, input bit rep, input int duty);
    bus.iBlinkCnt = 4'(cnt);
    bus.iOnMs = 16'(on);
    bus.iOffMs = 16'(off);
    bus.iGapMs = 16'(gap);
    bus.iRepeat = rep;
`ifdef LED_BLINK_DIM_EN
    bus.iDuty = 4'(duty);
`else
    m_duty = duty;
`endif
  endtask

  // one clock: drive, advance the model by the burst's tick position, compare outputs
  task automatic step(input logic tick, input logic start, input logic stop, input logic r);
    int p, b;
    bit done_e, led_e;
    bus.iTick1ms = tick;
    bus.iStart = start;
    bus.iStop = stop;
    rst = r;
    @(posedge clk);
    #1;
    done_e = 0;
    if (r) begin
      m_act = 0;
      m_pwm = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 16;
      if (stop) m_act = 0;
      else if (!m_act) begin
        if (start && bus.iBlinkCnt != 0) begin
          m_act = 1;
          m_k = 0;
          m_cnt = int'(bus.iBlinkCnt);
          m_on = int'(bus.iOnMs);
          m_off = int'(bus.iOffMs);
          m_gap = int'(bus.iGapMs);
          m_rep = bus.iRepeat;
`ifdef LED_BLINK_DIM_EN
          m_duty = int'(bus.iDuty);
`endif
        end
      end else if (tick) begin
        m_k++;
        if (!m_rep && m_k == m_cnt * (eff(m_on) + eff(m_off))) begin
          m_act = 0;
          done_e = 1;
        end else if (m_k == m_cnt * (eff(m_on) + eff(m_off)) + eff(m_gap)) m_k = 0;
      end
    end
    p = eff(m_on) + eff(m_off);
    b = m_cnt * p;
    led_e = m_act && (m_k < b) && ((m_k % p) < eff(m_on));
`ifdef LED_BLINK_DIM_EN
    led_e = led_e && (m_pwm < m_duty);
`endif
    chk("led", 32'(bus.oLed), 32'(led_e));
    chk("busy", 32'(bus.oBusy), 32'(m_act));
    chk("done", 32'(bus.oDone), 32'(done_e));
  endtask

  task automatic run(input int n, input int every);
    for (int i = 0; i < n; i++) step(logic'(i % every == every - 1), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cfg(0, 0, 0, 0, 0, 15);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_led", 32'(bus.oLed), 0);
    chk("reset_busy", 32'(bus.oBusy), 0);
    chk("reset_done", 32'(bus.oDone), 0);
    cfg(3, 2, 1, 0, 0, 15);
    step(1, 1, 0, 0);
    bus.iOnMs = 16'd7;
    run(44, 4);
    cfg(1, 1, 1, 3, 1, 15);
    step(0, 1, 0, 0);
    run(80, 4);
    step(0, 0, 1, 0);
    cfg(2, 0, 2, 0, 0, 15);
    step(0, 1, 0, 0);
    run(30, 2);
    cfg(0, 2, 2, 2, 0, 15);
    step(1, 1, 0, 0);
    run(8, 2);
    cfg(2, 1, 1, 1, 0, 15);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    step(0, 0, 0, 0);
    cfg(3, 5, 5, 1, 1, 4);
    step(0, 1, 0, 0);
    run(40, 3);
    step(0, 0, 0, 1);
    run(5, 2);
    for (int i = 0; i < 15000; i++) begin
      if ($urandom % 4 == 0)
        cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom % 2), $urandom_range(0, 15));
      step(logic'($urandom % 3 == 0), logic'($urandom % 8 == 0),
           logic'($urandom % 97 == 0), logic'($urandom % 499 == 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
